// File: rtl/char_stream_normalizer.sv
// Byte-stream normalizer: FIFO-buffered input, case folding, separator-run collapse
// to a single space, registered valid/ready output and a saturating word counter.
module char_stream_normalizer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int LOWER = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt
);

  // state   | meaning
  // START   | nothing emitted yet; leading separators are dropped
  // IN_WORD | last emitted char was a word char
  // GAP     | a space was emitted; further separators are dropped
  typedef enum logic [1:0] {START, IN_WORD, GAP} state_e;

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_char_q, out_char_d;
  logic [CNT_W-1:0] word_cnt_q;
  logic             cnt_inc;

  logic       fifo_full, fifo_empty, push, pop;
  logic [7:0] head, folded;
  logic       is_word, is_upper;

  assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign in_ready   = !reset && !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = (!out_valid_q || out_ready) && !fifo_empty;

  assign head     = mem_q[rd_ptr_q];
  assign is_upper = (head >= 8'h41) && (head <= 8'h5A);
  assign is_word  = is_upper
                 || ((head >= 8'h61) && (head <= 8'h7A))
                 || ((head >= 8'h30) && (head <= 8'h39));
  assign folded   = ((LOWER != 0) && is_upper) ? (head + 8'h20) : head;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    cnt_inc     = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (pop) begin
      unique case (state_q)
        START, GAP: begin
          if (is_word) begin
            out_char_d  = folded;
            out_valid_d = 1'b1;
            cnt_inc     = 1'b1;
            state_d     = IN_WORD;
          end
        end
        IN_WORD: begin
          out_valid_d = 1'b1;
          if (is_word) begin
            out_char_d = folded;
          end else begin
            out_char_d = 8'h20;
            state_d    = GAP;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_char;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= START;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      word_cnt_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      if (cnt_inc && (word_cnt_q != '1)) word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign word_cnt  = word_cnt_q;

endmodule
